dram_bank_model: RTL and testbench

- Cycle-accurate, parametrised model of a single DRAM bank with a one-row buffer, for use in the memory-subsystem benches and the cache/memory-controller testbenches.
- Accepts read and write requests over a valid/ready handshake.
- Returns a response after a latency chosen by row-buffer state: hit, open from empty, or conflict.
- All timing comes from synthesizable counters; no delay statements.

---
 rtl/dram_bank_model.sv | 184 ++++++++++++++++++
 tb/tb_dram_bank_model.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dram_bank_model.sv
// Single DRAM bank with a one-row buffer and hit/open/conflict response latency.
// Optional DRAM_BANK_STATS_EN adds saturating per-class acceptance counters.
module dram_bank_model #(
  parameter int DATA_W     = 32,
  parameter int ROW_W      = 4,
  parameter int T_HIT      = 1,
  parameter int T_OPEN     = 10,
  parameter int T_CONFLICT = 20,
  parameter int CLOSE_PAGE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ROW_W-1:0]  req_row,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic [1:0]        rsp_kind
`ifdef DRAM_BANK_STATS_EN
  ,
  output logic [15:0]       stat_hit,
  output logic [15:0]       stat_open,
  output logic [15:0]       stat_conflict
`endif
);

  localparam int DEPTH = 2 ** ROW_W;
  localparam int CNT_W = $clog2(T_CONFLICT + 1);

  localparam logic [1:0] K_HIT      = 2'd0;
  localparam logic [1:0] K_OPEN     = 2'd1;
  localparam logic [1:0] K_CONFLICT = 2'd2;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_row_open;
  logic [ROW_W-1:0]   r_open_row;
  logic [ROW_W-1:0]   r_pend_row;
  logic               r_pend_we;
  logic [DATA_W-1:0]  r_pend_wdata;
  logic [1:0]         r_pend_kind;
  logic               r_rsp_valid;
  logic [DATA_W-1:0]  r_rsp_data;
  logic [1:0]         r_rsp_kind;

  logic               w_accept;
  logic               w_hit;
  logic [1:0]         w_kind;
  logic [CNT_W-1:0]   w_lat;
  logic               w_fire_now;
  logic               w_fire_busy;
  logic               w_fire;
  logic [ROW_W-1:0]   w_fire_row;
  logic               w_fire_we;
  logic [DATA_W-1:0]  w_fire_wdata;
  logic [1:0]         w_fire_kind;
  logic               w_mem_we;
  logic [DATA_W-1:0]  w_words [DEPTH];

  assign req_ready = (r_state == S_IDLE);
  assign w_accept  = req_valid && req_ready;
  assign w_hit     = r_row_open && (r_open_row == req_row);

  always_comb begin
    w_kind = K_CONFLICT;
    w_lat  = CNT_W'(T_CONFLICT);
    if (w_hit) begin
      w_kind = K_HIT;
      w_lat  = CNT_W'(T_HIT);
    end else if (!r_row_open) begin
      w_kind = K_OPEN;
      w_lat  = CNT_W'(T_OPEN);
    end
  end

  // A latency-1 access responds at its own accepting edge; all others go through BUSY.
  assign w_fire_now   = w_accept && (w_lat == CNT_W'(1));
  assign w_fire       = w_fire_now || w_fire_busy;
  assign w_fire_row   = w_fire_now ? req_row   : r_pend_row;
  assign w_fire_we    = w_fire_now ? req_we    : r_pend_we;
  assign w_fire_wdata = w_fire_now ? req_wdata : r_pend_wdata;
  assign w_fire_kind  = w_fire_now ? w_kind    : r_pend_kind;
  assign w_mem_we     = w_fire && w_fire_we && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_fire_busy  = 1'b0;
    case (r_state)
      S_IDLE: if (w_accept && !w_fire_now) w_state_next = S_BUSY;
      S_BUSY: if (r_cnt == '0) begin
        w_state_next = S_IDLE;
        w_fire_busy  = 1'b1;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_row_open   <= 1'b0;
      r_open_row   <= '0;
      r_pend_row   <= '0;
      r_pend_we    <= 1'b0;
      r_pend_wdata <= '0;
      r_pend_kind  <= K_HIT;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_kind   <= K_HIT;
    end else begin
      if (w_accept && !w_fire_now) begin
        r_cnt <= w_lat - CNT_W'(2);
      end else if (r_state == S_BUSY && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_accept) begin
        r_open_row   <= req_row;
        r_pend_row   <= req_row;
        r_pend_we    <= req_we;
        r_pend_wdata <= req_wdata;
        r_pend_kind  <= w_kind;
      end
      // Close-page: the response edge closes the row, even for a same-edge access.
      if (CLOSE_PAGE != 0 && w_fire) r_row_open <= 1'b0;
      else if (w_accept)             r_row_open <= 1'b1;
      r_rsp_valid <= w_fire;
      if (w_fire) begin
        r_rsp_data <= w_fire_we ? w_fire_wdata : w_words[w_fire_row];
        r_rsp_kind <= w_fire_kind;
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_kind  = r_rsp_kind;

  // Storage is never reset; each word starts out holding its own row index.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [DATA_W-1:0] r_word = DATA_W'(gi);
      always_ff @(posedge clk) begin
        if (w_mem_we && (w_fire_row == ROW_W'(gi))) r_word <= w_fire_wdata;
      end
      assign w_words[gi] = r_word;
    end
  endgenerate

`ifdef DRAM_BANK_STATS_EN
  logic [15:0] r_stat_hit;
  logic [15:0] r_stat_open;
  logic [15:0] r_stat_conflict;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_hit      <= '0;
      r_stat_open     <= '0;
      r_stat_conflict <= '0;
    end else if (w_accept) begin
      if (w_kind == K_HIT && r_stat_hit != 16'hFFFF)
        r_stat_hit <= r_stat_hit + 16'd1;
      if (w_kind == K_OPEN && r_stat_open != 16'hFFFF)
        r_stat_open <= r_stat_open + 16'd1;
      if (w_kind == K_CONFLICT && r_stat_conflict != 16'hFFFF)
        r_stat_conflict <= r_stat_conflict + 16'd1;
    end
  end

  assign stat_hit      = r_stat_hit;
  assign stat_open     = r_stat_open;
  assign stat_conflict = r_stat_conflict;
`endif

endmodule

// File: tb/tb_dram_bank_model.sv
// Directed bench for dram_bank_model: open-page instance plus a close-page instance.
module tb_dram_bank_model;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        cp_valid;
  logic        req_we;
  logic [3:0]  req_row;
  logic [31:0] req_wdata;

  logic        req_ready, rsp_valid;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_kind;
  logic        cp_ready, cp_rsp_valid;
  logic [31:0] cp_rsp_data;
  logic [1:0]  cp_rsp_kind;
`ifdef DRAM_BANK_STATS_EN
  logic [15:0] s1_hit, s1_open, s1_conflict;
  logic [15:0] s2_hit, s2_open, s2_conflict;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dram_bank_model u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_row(req_row), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_kind(rsp_kind)
`ifdef DRAM_BANK_STATS_EN
    , .stat_hit(s1_hit), .stat_open(s1_open), .stat_conflict(s1_conflict)
`endif
  );

  dram_bank_model #(.CLOSE_PAGE(1)) u_dut_cp (
    .clk(clk), .rst_n(rst_n), .req_valid(cp_valid), .req_ready(cp_ready),
    .req_we(req_we), .req_row(req_row), .req_wdata(req_wdata),
    .rsp_valid(cp_rsp_valid), .rsp_data(cp_rsp_data), .rsp_kind(cp_rsp_kind)
`ifdef DRAM_BANK_STATS_EN
    , .stat_hit(s2_hit), .stat_open(s2_open), .stat_conflict(s2_conflict)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request; lat counts cycles from acceptance to the edge where rsp_valid is sampled.
  task automatic access(input bit cp, input logic we, input logic [3:0] row,
                        input logic [31:0] wd, output int lat, output int rdy_low,
                        output logic [31:0] data, output logic [1:0] kind);
    int guard;
    @(negedge clk);
    req_we = we; req_row = row; req_wdata = wd;
    if (cp) cp_valid = 1'b1; else req_valid = 1'b1;
    guard = 0;
    while (!(cp ? cp_ready : req_ready) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    req_valid = 1'b0; cp_valid = 1'b0;
    lat = 1; rdy_low = 0;
    while (!(cp ? cp_rsp_valid : rsp_valid) && lat < 60) begin
      if (!(cp ? cp_ready : req_ready)) rdy_low++;
      @(negedge clk);
      lat++;
    end
    if (!(cp ? cp_rsp_valid : rsp_valid)) lat = -1;
    data = cp ? cp_rsp_data : rsp_data;
    kind = cp ? cp_rsp_kind : rsp_kind;
  endtask

  initial begin
    int lat, rdy_low, seen;
    logic [31:0] d;
    logic [1:0]  k;

    rst_n = 1'b0; req_valid = 1'b0; cp_valid = 1'b0;
    req_we = 1'b0; req_row = '0; req_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_kind", 32'(rsp_kind), 32'd0);
    rst_n = 1'b1;

    // 1: open from empty
    access(1'b0, 1'b0, 4'd5, 32'd0, lat, rdy_low, d, k);
    $display("t1 read row5: lat=%0d ready_low=%0d data=%0h kind=%0d", lat, rdy_low, d, k);
    chk("t1_lat", 32'(lat), 32'd10);
    chk("t1_ready_low", 32'(rdy_low), 32'd9);
    chk("t1_data", d, 32'd5);
    chk("t1_kind", 32'(k), 32'd1);

    // 2: three back-to-back hits
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_row = 4'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) req_valid = 1'b0;
      $display("t2 hit %0d: valid=%0d data=%0h kind=%0d", i, rsp_valid, rsp_data, rsp_kind);
      chk("t2_valid", 32'(rsp_valid), 32'd1);
      chk("t2_data", rsp_data, 32'd5);
      chk("t2_kind", 32'(rsp_kind), 32'd0);
    end
    @(negedge clk);
    chk("t2_valid_end", 32'(rsp_valid), 32'd0);

    // 3: conflict
    access(1'b0, 1'b0, 4'd9, 32'd0, lat, rdy_low, d, k);
    $display("t3 read row9: lat=%0d data=%0h kind=%0d", lat, d, k);
    chk("t3_lat", 32'(lat), 32'd20);
    chk("t3_data", d, 32'd9);
    chk("t3_kind", 32'(k), 32'd2);

    // 4: write hit then immediate read hit
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_row = 4'd9; req_wdata = 32'hDEADBEEF;
    @(negedge clk);
    req_we = 1'b0;
    $display("t4 write: valid=%0d data=%0h kind=%0d", rsp_valid, rsp_data, rsp_kind);
    chk("t4_wr_valid", 32'(rsp_valid), 32'd1);
    chk("t4_wr_data", rsp_data, 32'hDEADBEEF);
    chk("t4_wr_kind", 32'(rsp_kind), 32'd0);
    @(negedge clk);
    req_valid = 1'b0;
    $display("t4 read: valid=%0d data=%0h kind=%0d", rsp_valid, rsp_data, rsp_kind);
    chk("t4_rd_valid", 32'(rsp_valid), 32'd1);
    chk("t4_rd_data", rsp_data, 32'hDEADBEEF);
    chk("t4_rd_kind", 32'(rsp_kind), 32'd0);
    @(negedge clk);
    chk("t4_valid_end", 32'(rsp_valid), 32'd0);

    // 5: reset while a conflict read is in flight
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_row = 4'd3;
    @(negedge clk);
    req_valid = 1'b0;
    seen = 0;
    repeat (6) begin
      if (rsp_valid) seen = 1;
      @(negedge clk);
    end
    if (rsp_valid) seen = 1;
    $display("t5 before reset: rsp_seen=%0d ready=%0d", seen, req_ready);
    chk("t5_no_early_rsp", 32'(seen), 32'd0);
    chk("t5_busy_ready", 32'(req_ready), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_ready", 32'(req_ready), 32'd1);
    chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 1'b0, 4'd3, 32'd0, lat, rdy_low, d, k);
    $display("t5 read row3: lat=%0d data=%0h kind=%0d", lat, d, k);
    chk("t5_lat", 32'(lat), 32'd10);
    chk("t5_data", d, 32'd3);
    chk("t5_kind", 32'(k), 32'd1);
    access(1'b0, 1'b0, 4'd9, 32'd0, lat, rdy_low, d, k);
    $display("t5 read row9: lat=%0d data=%0h kind=%0d", lat, d, k);
    chk("t5_r9_lat", 32'(lat), 32'd20);
    chk("t5_r9_data", d, 32'hDEADBEEF);
    chk("t5_r9_kind", 32'(k), 32'd2);

    // 6: close-page instance, every access opens from empty
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b0, 4'd2, 32'd0, lat, rdy_low, d, k);
      $display("t6 cp read %0d row2: lat=%0d data=%0h kind=%0d", i, lat, d, k);
      chk("t6_lat", 32'(lat), 32'd10);
      chk("t6_data", d, 32'd2);
      chk("t6_kind", 32'(k), 32'd1);
    end
`ifdef DRAM_BANK_STATS_EN
    $display("t6 stats: hit=%0d open=%0d conflict=%0d", s2_hit, s2_open, s2_conflict);
    chk("t6_stat_open", 32'(s2_open), 32'd4);
    chk("t6_stat_hit", 32'(s2_hit), 32'd0);
    chk("t6_stat_conflict", 32'(s2_conflict), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
